// File: rtl/data_ram_resp_pkg.sv
// Shared types and constants for the data-memory responder.
// Byte-lane writes are enabled by defining DRAM_BYTE_LANE_EN.
package data_ram_resp_pkg;

    typedef enum logic [1:0] {
        DRAM_IDLE = 2'd0,
        DRAM_WAIT = 2'd1,
        DRAM_RESP = 2'd2
    } dram_state_e;

    localparam logic        RW_READ  = 1'b1;
    localparam logic        RW_WRITE = 1'b0;
    localparam logic [31:0] ZeroWord = 32'h0000_0000;
    localparam logic        True_v   = 1'b1;
    localparam logic        False_v  = 1'b0;
    localparam logic [3:0]  SelFull  = 4'b1111;

    // Legal lane masks: full word, aligned halves, or one byte at its offset.
    function automatic logic sel_legal(
        input logic [3:0] sel,
        input logic [1:0] off
    );
        logic [3:0] one;
        logic       ok;
        one = 4'b0001 << off;
        ok  = ((sel == SelFull) && (off == 2'd0))
           || ((sel == 4'b0011) && (off == 2'd0))
           || ((sel == 4'b1100) && (off == 2'd2))
           || (sel == one);
        return ok;
    endfunction

endpackage

// File: rtl/data_ram_resp_dram_array.sv
// Word-organised data store: byte-enabled synchronous write,
// combinational read by word index. Contents are never reset.
module dram_array #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [3:0]        i_be,
    input  logic [ADDR_W-1:0] i_idx,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata
);

    logic [31:0] r_mem [2**ADDR_W];

    // Commit enabled bytes of the addressed word.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_be[b]) begin
                    r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/data_ram_resp.sv
// Data-memory responder: wait-state FSM, access checks, ready/err strobe.
// Define DRAM_BYTE_LANE_EN to add mem_sel_i byte-lane writes.
module data_ram_resp
    import data_ram_resp_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_cs_i,
    input  logic        mem_rw_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
`ifdef DRAM_BYTE_LANE_EN
    input  logic [3:0]  mem_sel_i,
`endif
    output logic [31:0] mem_rdata_o,
    output logic        mem_ready_o,
    output logic        mem_err_o
);

    localparam logic [3:0] WaitLd = 4'(WAIT_CYCLES);

    dram_state_e       r_state;
    logic [3:0]        r_cnt;
    logic              r_rw;
    logic [31:0]       r_addr;
    logic [31:0]       r_wdata;
    logic              r_ready;
    logic              r_err;
    logic [31:0]       r_rdata;

    logic              w_idle;
    logic              w_fire;
    logic              w_rw;
    logic [31:0]       w_addr;
    logic [31:0]       w_wdata;
    logic              w_oor;
    logic              w_align_bad;
    logic              w_bad;
    logic              w_we;
    logic [3:0]        w_be;
    logic [ADDR_W-1:0] w_idx;
    logic [31:0]       w_rd_word;
    logic [31:0]       w_rdata_nxt;

    // In IDLE the live request is used so zero-wait accesses
    // resolve on the accepting edge; afterwards the latched copy.
    assign w_idle  = (r_state == DRAM_IDLE);
    assign w_rw    = w_idle ? mem_rw_i    : r_rw;
    assign w_addr  = w_idle ? mem_addr_i  : r_addr;
    assign w_wdata = w_idle ? mem_wdata_i : r_wdata;

`ifdef DRAM_BYTE_LANE_EN
    logic [3:0] r_sel;
    logic [3:0] w_sel;
    assign w_sel       = w_idle ? mem_sel_i : r_sel;
    assign w_align_bad = !sel_legal(w_sel, w_addr[1:0]);
    assign w_be        = w_sel;
`else
    assign w_align_bad = (w_addr[1:0] != 2'b00);
    assign w_be        = SelFull;
`endif

    assign w_oor = |(w_addr >> (ADDR_W + 2));
    assign w_bad = w_oor | w_align_bad;
    assign w_idx = w_addr[ADDR_W+1:2];

    // Edge on which the FSM enters RESP.
    assign w_fire = (w_idle && mem_cs_i && (WAIT_CYCLES == 0))
                 || ((r_state == DRAM_WAIT) && (r_cnt == 4'd1));

    assign w_we = w_fire && !w_bad && (w_rw == RW_WRITE);

    assign w_rdata_nxt = (!w_bad && (w_rw == RW_READ)) ? w_rd_word : ZeroWord;

    dram_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_be    (w_be),
        .i_idx   (w_idx),
        .i_wdata (w_wdata),
        .o_rdata (w_rd_word)
    );

    // Request FSM with registered response outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= DRAM_IDLE;
            r_cnt   <= 4'd0;
            r_rw    <= RW_READ;
            r_addr  <= ZeroWord;
            r_wdata <= ZeroWord;
            r_ready <= False_v;
            r_err   <= False_v;
            r_rdata <= ZeroWord;
`ifdef DRAM_BYTE_LANE_EN
            r_sel   <= 4'd0;
`endif
        end else begin
            unique case (r_state)
                DRAM_IDLE: begin
                    if (mem_cs_i) begin
                        r_rw    <= mem_rw_i;
                        r_addr  <= mem_addr_i;
                        r_wdata <= mem_wdata_i;
`ifdef DRAM_BYTE_LANE_EN
                        r_sel   <= mem_sel_i;
`endif
                        if (w_fire) begin
                            r_ready <= True_v;
                            r_err   <= w_bad;
                            r_rdata <= w_rdata_nxt;
                            r_state <= DRAM_RESP;
                        end else begin
                            r_cnt   <= WaitLd;
                            r_state <= DRAM_WAIT;
                        end
                    end
                end
                DRAM_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (w_fire) begin
                        r_ready <= True_v;
                        r_err   <= w_bad;
                        r_rdata <= w_rdata_nxt;
                        r_state <= DRAM_RESP;
                    end
                end
                DRAM_RESP: begin
                    r_ready <= False_v;
                    r_err   <= False_v;
                    r_rdata <= ZeroWord;
                    r_state <= DRAM_IDLE;
                end
                default: begin
                    r_state <= DRAM_IDLE;
                end
            endcase
        end
    end

    assign mem_ready_o = r_ready;
    assign mem_err_o   = r_err;
    assign mem_rdata_o = r_rdata;

endmodule

// File: tb/tb_data_ram_resp.sv
// Scoreboard bench for data_ram_resp: one instance with one wait
// state, one with zero wait states, shared clock and reset.
module tb_data_ram_resp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [1:0]  cs;
    logic [1:0]  rw;
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [3:0]  sel   [2];
    logic [31:0] rdata [2];
    logic [1:0]  rdy;
    logic [1:0]  err;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t        q0 [$];
    exp_t        q1 [$];
    logic [31:0] mdl0 [int];
    logic [31:0] mdl1 [int];
    bit          at_resp [2];

    data_ram_resp #(.ADDR_W(10), .WAIT_CYCLES(0)) u_dut0 (
        .clk         (clk),
        .rst         (rst_n),
        .mem_cs_i    (cs[0]),
        .mem_rw_i    (rw[0]),
        .mem_addr_i  (addr[0]),
        .mem_wdata_i (wdata[0]),
`ifdef DRAM_BYTE_LANE_EN
        .mem_sel_i   (sel[0]),
`endif
        .mem_rdata_o (rdata[0]),
        .mem_ready_o (rdy[0]),
        .mem_err_o   (err[0])
    );

    data_ram_resp #(.ADDR_W(10), .WAIT_CYCLES(1)) u_dut1 (
        .clk         (clk),
        .rst         (rst_n),
        .mem_cs_i    (cs[1]),
        .mem_rw_i    (rw[1]),
        .mem_addr_i  (addr[1]),
        .mem_wdata_i (wdata[1]),
`ifdef DRAM_BYTE_LANE_EN
        .mem_sel_i   (sel[1]),
`endif
        .mem_rdata_o (rdata[1]),
        .mem_ready_o (rdy[1]),
        .mem_err_o   (err[1])
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic exp_bad(input logic [31:0] a,
                                     input logic [3:0] s);
        logic       b;
        logic [3:0] one;
        b = ((a >> 12) != 0);
        one = 4'b0001;
        one = one << a[1:0];
`ifdef DRAM_BYTE_LANE_EN
        if (!((s == 4'hF && a[1:0] == 2'd0) ||
              (s == 4'h3 && a[1:0] == 2'd0) ||
              (s == 4'hC && a[1:0] == 2'd2) ||
              (s == one)))
            b = 1'b1;
`else
        if (a[1:0] != 2'd0) b = 1'b1;
        if (s != one && s == 4'h0) b = 1'b1;
`endif
        return b;
    endfunction

    function automatic logic [31:0] mread(input int d, input logic [31:0] a);
        int k;
        k = int'(a >> 2);
        if (d == 0) return mdl0.exists(k) ? mdl0[k] : 32'h0;
        return mdl1.exists(k) ? mdl1[k] : 32'h0;
    endfunction

    task automatic mwrite(input int d, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] s);
        logic [31:0] w;
        int k;
        k = int'(a >> 2);
        w = mread(d, a);
`ifdef DRAM_BYTE_LANE_EN
        for (int b = 0; b < 4; b++)
            if (s[b]) w[8*b +: 8] = wd[8*b +: 8];
`else
        w = wd;
`endif
        if (d == 0) mdl0[k] = w;
        else mdl1[k] = w;
    endtask

    // Drive one request, push its expected response, wait for it.
    task automatic access(input int d, input logic r, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] s,
                          input bit poke);
        exp_t e;
        int   acc;
        bit   done;
        acc     = cyc + (at_resp[d] ? 2 : 1);
        e.cyc   = acc + ((d == 0) ? 0 : 1);
        e.err   = exp_bad(a, s);
        e.rdata = 32'h0;
        if (!e.err) begin
            if (r) e.rdata = mread(d, a);
            else mwrite(d, a, wd, s);
        end
        if (d == 0) q0.push_back(e);
        else q1.push_back(e);
        cs[d] = 1'b1; rw[d] = r; addr[d] = a; wdata[d] = wd; sel[d] = s;
        if (poke) begin
            @(posedge clk); #1;
            addr[d]  = 32'h24;
            wdata[d] = 32'h0;
        end
        done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (qsize(d) == 0) begin
                done = 1'b1;
                break;
            end
        end
        check("timeout", {31'd0, done}, 32'd1);
        if (!done) begin
            if (d == 0) q0.delete();
            else q1.delete();
        end
        at_resp[d] = 1'b1;
    endtask

    task automatic idle(input int d);
        cs[d] = 1'b0;
        @(negedge clk); #1;
        at_resp[d] = 1'b0;
    endtask

    task automatic mon(input int d);
        exp_t e;
        if (rdy[d]) begin
            if (qsize(d) == 0) begin
                check($sformatf("spurious%0d", d), {31'd0, rdy[d]}, 32'd0);
            end else begin
                if (d == 0) e = q0.pop_front();
                else e = q1.pop_front();
                check($sformatf("lat%0d", d), cyc, e.cyc);
                check($sformatf("err%0d", d), {31'd0, err[d]}, {31'd0, e.err});
                check($sformatf("rdata%0d", d), rdata[d], e.rdata);
            end
        end else begin
            check($sformatf("idle_rdata%0d", d), rdata[d], 32'h0);
            check($sformatf("idle_err%0d", d), {31'd0, err[d]}, 32'd0);
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cs = 2'b00; rw = 2'b11;
        for (int d = 0; d < 2; d++) begin
            addr[d] = 32'h0; wdata[d] = 32'h0; sel[d] = 4'hF;
            at_resp[d] = 1'b0;
        end
        #1 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_ready", {31'd0, rdy[d]}, 32'd0);
            check("rst_err", {31'd0, err[d]}, 32'd0);
            check("rst_rdata", rdata[d], 32'h0);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); #1;

        access(1, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0); idle(1);
        access(1, 1'b1, 32'h10, 32'h0, 4'hF, 1'b0); idle(1);

        access(0, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0); idle(0);
        access(0, 1'b0, 32'h14, 32'h0BADF00D, 4'hF, 1'b0); idle(0);
        access(0, 1'b1, 32'h10, 32'h0, 4'hF, 1'b0);
        access(0, 1'b1, 32'h14, 32'h0, 4'hF, 1'b0);
        access(0, 1'b1, 32'h10, 32'h0, 4'hF, 1'b0); idle(0);

        access(1, 1'b0, 32'h11, 32'h0, 4'hF, 1'b0); idle(1);
        access(1, 1'b1, 32'h1000, 32'h0, 4'hF, 1'b0); idle(1);
        access(1, 1'b1, 32'h10, 32'h0, 4'hF, 1'b0); idle(1);

        access(1, 1'b0, 32'h24, 32'h55AA55AA, 4'hF, 1'b0); idle(1);
        access(1, 1'b0, 32'h20, 32'h12345678, 4'hF, 1'b1); idle(1);
        access(1, 1'b1, 32'h20, 32'h0, 4'hF, 1'b0); idle(1);
        access(1, 1'b1, 32'h24, 32'h0, 4'hF, 1'b0); idle(1);

        access(1, 1'b0, 32'h28, 32'h0, 4'hF, 1'b0); idle(1);

        // Reset while dut0 is responding and dut1 is waiting.
        cs[0] = 1'b1; rw[0] = 1'b1; addr[0] = 32'h10;
        cs[1] = 1'b1; rw[1] = 1'b0; addr[1] = 32'h28;
        wdata[1] = 32'hCAFEF00D;
        @(posedge clk); #2;
        check("pre_rst_ready0", {31'd0, rdy[0]}, 32'd1);
        check("pre_rst_rdata0", rdata[0], 32'hDEADBEEF);
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check("arst_ready", {31'd0, rdy[d]}, 32'd0);
            check("arst_err", {31'd0, err[d]}, 32'd0);
            check("arst_rdata", rdata[d], 32'h0);
        end
        cs = 2'b00;
        @(negedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); #1;
        at_resp[0] = 1'b0; at_resp[1] = 1'b0;
        access(1, 1'b1, 32'h28, 32'h0, 4'hF, 1'b0); idle(1);
        access(0, 1'b1, 32'h10, 32'h0, 4'hF, 1'b0); idle(0);

`ifdef DRAM_BYTE_LANE_EN
        access(1, 1'b0, 32'h30, 32'hFFFFFFFF, 4'hF, 1'b0); idle(1);
        access(1, 1'b0, 32'h31, 32'h0000AB00, 4'h2, 1'b0); idle(1);
        access(1, 1'b1, 32'h30, 32'h0, 4'hF, 1'b0); idle(1);
        access(1, 1'b0, 32'h30, 32'h0, 4'h2, 1'b0); idle(1);
        access(1, 1'b0, 32'h32, 32'h00110000, 4'hC, 1'b0); idle(1);
        access(1, 1'b0, 32'h36, 32'h11220000, 4'hC, 1'b0); idle(1);
        access(1, 1'b1, 32'h30, 32'h0, 4'hF, 1'b0); idle(1);
        access(1, 1'b1, 32'h34, 32'h0, 4'hF, 1'b0); idle(1);
`endif

        repeat (4) @(negedge clk);
        #1;
        check("q0_empty", q0.size(), 32'd0);
        check("q1_empty", q1.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
